// File: rtl/ddr_burst_pkg.sv
// Shared types and constants for the DDR burst engine.
package ddr_burst_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE_V    = 3'd0;
    localparam logic [2:0] ST_RD_CMD_V  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT_V = 3'd2;
    localparam logic [2:0] ST_DONE_RD_V = 3'd3;
    localparam logic [2:0] ST_WR_V      = 3'd4;
    localparam logic [2:0] ST_WR_TAIL_V = 3'd5;
    localparam logic [2:0] ST_DONE_WR_V = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_V,
        ST_RD_CMD  = ST_RD_CMD_V,
        ST_RD_WAIT = ST_RD_WAIT_V,
        ST_DONE_RD = ST_DONE_RD_V,
        ST_WR      = ST_WR_V,
        ST_WR_TAIL = ST_WR_TAIL_V,
        ST_DONE_WR = ST_DONE_WR_V
    } state_e;

    // MIG app_cmd opcodes
    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    // Arbiter grant identifiers
    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/ddr_rw_arbiter.sv
// Two-way round-robin arbiter between the read and write burst requesters.
// The last_grant register flips priority whenever both sides request.
module ddr_rw_arbiter
    import ddr_burst_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rd_req_i,
    input  logic wr_req_i,
    input  logic take_i,
    output logic valid_o,
    output logic grant_o
);

    logic last_grant_q;

    // Grant selection: a lone requester wins, otherwise the side not served last.
    always_comb begin
        valid_o = rd_req_i | wr_req_i;
        if (rd_req_i && wr_req_i) begin
            grant_o = (last_grant_q == GRANT_WR) ? GRANT_RD : GRANT_WR;
        end else if (rd_req_i) begin
            grant_o = GRANT_RD;
        end else begin
            grant_o = GRANT_WR;
        end
    end

    // Remember which side was served when the engine actually takes a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_WR;
        end else if (take_i && valid_o) begin
            last_grant_q <= grant_o;
        end
    end

endmodule

// File: rtl/ddr_burst_engine.sv
// Read/write burst engine between AP burst requesters and the MIG app_* port.
// Command and data counters run independently; zero-length bursts finish
// without touching MIG. Optional feature macro: DDR_BURST_MASK_EN passes
// wr_burst_mask through to app_wdf_mask; otherwise the mask is tied to 0.
// While init_calib_complete is low the FSM, counters and address freeze.
module ddr_burst_engine
    import ddr_burst_pkg::*;
#(
    parameter int DDR_DATA_WIDTH  = 128,
    parameter int DDR_ADDR_WIDTH  = 28,
    parameter int BURST_LEN_WIDTH = 10,
    parameter int ADDR_STEP       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_burst_req,
    input  logic [BURST_LEN_WIDTH-1:0]    rd_burst_len,
    input  logic [DDR_ADDR_WIDTH-1:0]     rd_burst_addr,
    output logic [DDR_DATA_WIDTH-1:0]     rd_burst_data,
    output logic                          rd_burst_data_valid,
    output logic                          rd_burst_finish,
    input  logic                          wr_burst_req,
    input  logic [BURST_LEN_WIDTH-1:0]    wr_burst_len,
    input  logic [DDR_ADDR_WIDTH-1:0]     wr_burst_addr,
    input  logic [DDR_DATA_WIDTH-1:0]     wr_burst_data,
    input  logic [DDR_DATA_WIDTH/8-1:0]   wr_burst_mask,
    output logic                          wr_burst_data_req,
    output logic                          wr_burst_finish,
    output logic                          burst_finish,
    output logic                          busy,
    output logic [DDR_ADDR_WIDTH-1:0]     app_addr,
    output logic [2:0]                    app_cmd,
    output logic                          app_en,
    output logic [DDR_DATA_WIDTH-1:0]     app_wdf_data,
    output logic [DDR_DATA_WIDTH/8-1:0]   app_wdf_mask,
    output logic                          app_wdf_wren,
    output logic                          app_wdf_end,
    input  logic [DDR_DATA_WIDTH-1:0]     app_rd_data,
    input  logic                          app_rd_data_valid,
    input  logic                          app_rdy,
    input  logic                          app_wdf_rdy,
    input  logic                          init_calib_complete
);

    localparam logic [DDR_ADDR_WIDTH-1:0]  STEP = DDR_ADDR_WIDTH'(ADDR_STEP);
    localparam logic [BURST_LEN_WIDTH-1:0] ZERO = '0;

    state_e                        state_q;
    logic [BURST_LEN_WIDTH-1:0]    len_q;
    logic [BURST_LEN_WIDTH-1:0]    cmd_cnt_q, cmd_cnt_d;
    logic [BURST_LEN_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
    logic [BURST_LEN_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
    logic [DDR_ADDR_WIDTH-1:0]     app_addr_q;
    logic [2:0]                    app_cmd_q;
    logic                          app_en_q;
    logic                          rd_fin_q, wr_fin_q, busy_q;

    logic cmd_acc, rd_active, wr_active, rd_beat, wr_beat;
    logic arb_valid, arb_grant, grant_take;

    ddr_rw_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req_i (rd_burst_req),
        .wr_req_i (wr_burst_req),
        .take_i   (grant_take),
        .valid_o  (arb_valid),
        .grant_o  (arb_grant)
    );

    // Handshake qualifiers and next counter values; all gated by calibration
    // so nothing moves while the memory is not ready.
    always_comb begin
        cmd_acc    = app_en_q & app_rdy & init_calib_complete;
        rd_active  = (state_q == ST_RD_CMD) | (state_q == ST_RD_WAIT);
        wr_active  = (state_q == ST_WR) | (state_q == ST_WR_TAIL);
        rd_beat    = rd_active & app_rd_data_valid & init_calib_complete;
        wr_beat    = wr_active & (wr_cnt_q != len_q) & app_wdf_rdy & init_calib_complete;
        cmd_cnt_d  = cmd_cnt_q + {{(BURST_LEN_WIDTH-1){1'b0}}, cmd_acc};
        rd_cnt_d   = rd_cnt_q  + {{(BURST_LEN_WIDTH-1){1'b0}}, rd_beat};
        wr_cnt_d   = wr_cnt_q  + {{(BURST_LEN_WIDTH-1){1'b0}}, wr_beat};
        grant_take = (state_q == ST_IDLE) & init_calib_complete & arb_valid;
    end

    assign rd_burst_data       = app_rd_data;
    assign rd_burst_data_valid = rd_beat;
    assign rd_burst_finish     = rd_fin_q;
    assign wr_burst_data_req   = wr_beat;
    assign wr_burst_finish     = wr_fin_q;
    assign burst_finish        = rd_fin_q | wr_fin_q;
    assign busy                = busy_q;
    assign app_addr            = app_addr_q;
    assign app_cmd             = app_cmd_q;
    assign app_en              = app_en_q;
    assign app_wdf_data        = wr_burst_data;
    assign app_wdf_wren        = wr_beat;
    assign app_wdf_end         = wr_beat;

`ifdef DDR_BURST_MASK_EN
    assign app_wdf_mask = wr_burst_mask;
`else
    logic unused_wr_mask;
    assign unused_wr_mask = ^wr_burst_mask;
    assign app_wdf_mask   = '0;
`endif

    // Burst FSM with command address generator, counters and registered outputs.
    // Finishing checks use the post-increment counts so a last command and a
    // last data beat in the same cycle go straight to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cmd_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            app_addr_q <= '0;
            app_cmd_q  <= APP_CMD_WRITE;
            app_en_q   <= 1'b0;
            rd_fin_q   <= 1'b0;
            wr_fin_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else if (init_calib_complete) begin
            rd_fin_q  <= 1'b0;
            wr_fin_q  <= 1'b0;
            cmd_cnt_q <= cmd_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            if (cmd_acc) begin
                app_addr_q <= app_addr_q + STEP;
                if (cmd_cnt_d == len_q) begin
                    app_en_q <= 1'b0;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        busy_q    <= 1'b1;
                        cmd_cnt_q <= '0;
                        rd_cnt_q  <= '0;
                        wr_cnt_q  <= '0;
                        if (arb_grant == GRANT_RD) begin
                            len_q      <= rd_burst_len;
                            app_addr_q <= rd_burst_addr;
                            app_cmd_q  <= APP_CMD_READ;
                            app_en_q   <= (rd_burst_len != ZERO);
                            state_q    <= ST_RD_CMD;
                        end else begin
                            len_q      <= wr_burst_len;
                            app_addr_q <= wr_burst_addr;
                            app_cmd_q  <= APP_CMD_WRITE;
                            app_en_q   <= (wr_burst_len != ZERO);
                            state_q    <= ST_WR;
                        end
                    end
                end
                ST_RD_CMD: begin
                    if (cmd_cnt_d == len_q) begin
                        if (rd_cnt_d == len_q) begin
                            state_q  <= ST_DONE_RD;
                            rd_fin_q <= 1'b1;
                        end else begin
                            state_q <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_cnt_d == len_q) begin
                        state_q  <= ST_DONE_RD;
                        rd_fin_q <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (wr_cnt_d == len_q) begin
                        if (cmd_cnt_d == len_q) begin
                            state_q  <= ST_DONE_WR;
                            wr_fin_q <= 1'b1;
                        end else begin
                            state_q <= ST_WR_TAIL;
                        end
                    end
                end
                ST_WR_TAIL: begin
                    if (cmd_cnt_d == len_q) begin
                        state_q  <= ST_DONE_WR;
                        wr_fin_q <= 1'b1;
                    end
                end
                ST_DONE_RD, ST_DONE_WR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_burst_engine.sv
// Scoreboard bench for ddr_burst_engine: expectations are pushed when a
// burst is issued, a monitor pops them as the DUT presents traffic.
// Honours DDR_BURST_MASK_EN for the expected write mask.
module tb_ddr_burst_engine;
    import ddr_burst_pkg::*;

    localparam int DW = 128;
    localparam int AW = 28;
    localparam int LW = 10;

    logic clk, rst_n;
    logic rd_burst_req, wr_burst_req;
    logic [LW-1:0] rd_burst_len, wr_burst_len;
    logic [AW-1:0] rd_burst_addr, wr_burst_addr;
    logic [DW-1:0] rd_burst_data, wr_burst_data, app_wdf_data, app_rd_data;
    logic [DW/8-1:0] wr_burst_mask, app_wdf_mask;
    logic rd_burst_data_valid, rd_burst_finish, wr_burst_data_req, wr_burst_finish;
    logic burst_finish, busy, app_en, app_wdf_wren, app_wdf_end;
    logic [AW-1:0] app_addr;
    logic [2:0] app_cmd;
    logic app_rd_data_valid, app_rdy, app_wdf_rdy, init_calib_complete;

    ddr_burst_engine dut (
        .clk(clk), .rst_n(rst_n),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_finish(rd_burst_finish),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data), .wr_burst_mask(wr_burst_mask),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
        .burst_finish(burst_finish), .busy(busy),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .init_calib_complete(init_calib_complete)
    );

    typedef struct packed {
        logic       is_wr;
        int         len;
        int         cmd_mark;
        int         dat_mark;
    } fin_t;

    int checks = 0;
    int errors = 0;

    logic [AW+2:0]   exp_cmd[$];
    logic [DW-1:0]   exp_rd[$];
    logic [DW-1:0]   exp_wdf[$];
    logic [DW/8-1:0] exp_msk[$];
    fin_t            exp_fin[$];
    int tot_cmd_push = 0, tot_cmd_pop = 0;
    int tot_dat_push = 0, tot_dat_pop = 0;

    logic [DW-1:0]   data_mem[0:2047];
    logic [DW/8-1:0] mask_mem[0:2047];
    int   wr_base = 0;
    int   wr_idx = 0;
    logic model_last_wr = 1'b1;

    logic [AW-1:0] pend[$];
    bit   rdy_fixed = 0;
    int   stall_token = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
        return {4{4'hC, a}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a burst of len beats from addr yields len commands at
    // addr + 8*i (mod 2**AW), and len data beats, then one finish pulse.
    task automatic push_exp(input bit is_wr, input int len, input logic [AW-1:0] addr);
        fin_t f;
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = addr + AW'(8 * i);
            exp_cmd.push_back({is_wr ? APP_CMD_WRITE : APP_CMD_READ, a});
            if (is_wr) begin
                exp_wdf.push_back(data_mem[wr_base + i]);
`ifdef DDR_BURST_MASK_EN
                exp_msk.push_back(mask_mem[wr_base + i]);
`else
                exp_msk.push_back('0);
`endif
            end else begin
                exp_rd.push_back(rd_pat(a));
            end
        end
        if (is_wr) wr_base += len;
        tot_cmd_push += len;
        tot_dat_push += len;
        f.is_wr = is_wr; f.len = len;
        f.cmd_mark = tot_cmd_push; f.dat_mark = tot_dat_push;
        exp_fin.push_back(f);
        model_last_wr = is_wr;
    endtask

    // MIG model: accepts commands, returns read data by address, FWFT write source.
    initial begin
        int stall_seen = 0;
        int stall_cnt = 0;
        bit acc, take_wr;
        for (int i = 0; i < 2048; i++) begin
            data_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            mask_mem[i] = 16'($urandom);
        end
        app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0; app_rd_data = '0;
        wr_burst_data = data_mem[0]; wr_burst_mask = mask_mem[0];
        forever begin
            @(negedge clk);
            acc = app_en & app_rdy & init_calib_complete;
            if (acc && app_cmd == APP_CMD_READ) pend.push_back(app_addr);
            if (acc && stall_token != stall_seen) begin
                stall_seen = stall_token;
                stall_cnt = 5;
            end
            take_wr = wr_burst_data_req;
            @(posedge clk);
            #2;
            if (take_wr) begin
                wr_idx++;
                wr_burst_data = data_mem[wr_idx];
                wr_burst_mask = mask_mem[wr_idx];
            end
            if (stall_cnt > 0) begin
                app_rdy = 0;
                stall_cnt--;
            end else begin
                app_rdy = rdy_fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            app_wdf_rdy = rdy_fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (pend.size() > 0 && init_calib_complete && $urandom_range(0, 2) != 0) begin
                app_rd_data_valid = 1;
                app_rd_data = rd_pat(pend.pop_front());
            end else begin
                app_rd_data_valid = 0;
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents traffic.
    initial begin
        bit prev_rdv = 0, prev_wren = 0, prev_acc = 0;
        bit acc;
        forever begin
            @(negedge clk);
            acc = app_en & app_rdy & init_calib_complete;
            if (rst_n) begin
                if (acc) begin
                    if (exp_cmd.size() == 0) chk("cmd_unexpected", {app_cmd, app_addr}, '0);
                    else begin
                        chk("cmd", {app_cmd, app_addr}, exp_cmd.pop_front());
                        tot_cmd_pop++;
                    end
                end
                if (app_wdf_wren) begin
                    chk("wdf_end", app_wdf_end, 1'b1);
                    if (exp_wdf.size() == 0) chk("wdf_unexpected", app_wdf_data, '0);
                    else begin
                        chk("wdf_data", app_wdf_data, exp_wdf.pop_front());
                        chk("wdf_mask", app_wdf_mask, exp_msk.pop_front());
                        tot_dat_pop++;
                    end
                end
                if (rd_burst_data_valid) begin
                    if (exp_rd.size() == 0) chk("rd_unexpected", rd_burst_data, '0);
                    else begin
                        chk("rd_data", rd_burst_data, exp_rd.pop_front());
                        tot_dat_pop++;
                    end
                end
                if (!init_calib_complete) chk("no_wren_uncal", {wr_burst_data_req, app_wdf_wren}, '0);
                if (rd_burst_finish || wr_burst_finish) begin
                    chk("finish_or", burst_finish, 1'b1);
                    chk("finish_busy", busy, 1'b1);
                    if (exp_fin.size() == 0) chk("finish_unexpected", {rd_burst_finish, wr_burst_finish}, '0);
                    else begin
                        fin_t f;
                        f = exp_fin.pop_front();
                        chk("finish_kind", {rd_burst_finish, wr_burst_finish}, f.is_wr ? 2'b01 : 2'b10);
                        chk("finish_cmds", tot_cmd_pop, f.cmd_mark);
                        chk("finish_beats", tot_dat_pop, f.dat_mark);
                        if (f.len > 0)
                            chk("finish_timing", f.is_wr ? (prev_wren | prev_acc) : prev_rdv, 1'b1);
                    end
                end
            end
            prev_rdv = rd_burst_data_valid;
            prev_wren = app_wdf_wren;
            prev_acc = acc;
        end
    end

    task automatic wait_busy(input logic val);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== val && n < 2000);
        if (busy !== val) chk("busy_timeout", busy, val);
    endtask

    task automatic wait_finish(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (burst_finish !== 1'b1 && n < 3000);
        if (burst_finish !== 1'b1) chk("finish_timeout", burst_finish, 1'b1);
    endtask

    task automatic set_req(input bit is_wr, input logic v, input int len, input logic [AW-1:0] addr);
        if (is_wr) begin
            wr_burst_req = v; wr_burst_len = LW'(len); wr_burst_addr = addr;
        end else begin
            rd_burst_req = v; rd_burst_len = LW'(len); rd_burst_addr = addr;
        end
    endtask

    task automatic do_single(input bit is_wr, input int len, input logic [AW-1:0] addr, input bit drop_cal);
        int n;
        push_exp(is_wr, len, addr);
        @(posedge clk); #1;
        set_req(is_wr, 1'b1, len, addr);
        wait_busy(1'b1);
        @(posedge clk); #1;
        set_req(is_wr, 1'b0, 0, '0);
        if (drop_cal) begin
            @(posedge clk); #1;
            init_calib_complete = 0;
            repeat (3) @(posedge clk);
            #1 init_calib_complete = 1;
        end
        wait_finish(n);
        if (len == 0) chk("len0_finish_delay", n, 1);
        @(negedge clk);
        chk("busy_after_finish", busy, 1'b0);
    endtask

    task automatic do_both(input int rlen, input logic [AW-1:0] raddr, input int wlen, input logic [AW-1:0] waddr);
        bit first_wr;
        int n;
        first_wr = !model_last_wr;
        if (first_wr) begin
            push_exp(1, wlen, waddr); push_exp(0, rlen, raddr);
        end else begin
            push_exp(0, rlen, raddr); push_exp(1, wlen, waddr);
        end
        @(posedge clk); #1;
        set_req(0, 1'b1, rlen, raddr);
        set_req(1, 1'b1, wlen, waddr);
        wait_busy(1'b1);
        @(posedge clk); #1;
        set_req(first_wr, 1'b0, 0, '0);
        wait_finish(n);
        @(negedge clk);
        chk("busy_between", busy, 1'b0);
        wait_busy(1'b1);
        @(posedge clk); #1;
        set_req(!first_wr, 1'b0, 0, '0);
        wait_finish(n);
        @(negedge clk);
        chk("busy_after_pair", busy, 1'b0);
    endtask

    // Stimulus
    initial begin
        int n;
        rst_n = 0; init_calib_complete = 1;
        rd_burst_req = 0; wr_burst_req = 0;
        rd_burst_len = '0; wr_burst_len = '0;
        rd_burst_addr = '0; wr_burst_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_app_cmd_addr", {app_cmd, app_addr}, '0);
        chk("rst_busy_fin", {busy, rd_burst_finish, wr_burst_finish, app_wdf_wren}, '0);
        @(posedge clk); #1 rst_n = 1;

        rdy_fixed = 1;
        do_single(0, 4, 28'h100, 0);
        stall_token++;
        do_single(1, 3, 28'h200, 0);
        rdy_fixed = 0;
        do_both(5, 28'h1000, 4, 28'h2000);
        do_both(3, 28'h3000, 6, 28'h4000);
        do_single(1, 0, 28'h500, 0);
        do_single(0, 0, 28'h600, 0);
        do_single(1, 8, 28'h700, 1);
        for (int i = 0; i < 4; i++) mask_mem[wr_base + i] = 16'h00FF;
        do_single(1, 4, 28'hFFFFFF0, 0);

        for (int k = 0; k < 40; k++) begin
            int t, l1, l2;
            logic [AW-1:0] a1, a2;
            t  = $urandom_range(0, 2);
            l1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            l2 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            a1 = ($urandom_range(0, 3) == 0) ? AW'(28'hFFFFFF8 - 8 * $urandom_range(0, 4)) : AW'($urandom);
            a2 = AW'($urandom);
            rdy_fixed = ($urandom_range(0, 3) == 0);
            if (t == 2) do_both(l1, a1, l2, a2);
            else do_single(t == 1, l1, a1, 0);
        end

        // Reset in the middle of a read burst
        rdy_fixed = 1;
        push_exp(0, 8, 28'h800);
        @(posedge clk); #1;
        set_req(0, 1'b1, 8, 28'h800);
        wait_busy(1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 0, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        exp_cmd.delete(); exp_rd.delete(); exp_fin.delete();
        tot_cmd_pop = tot_cmd_push; tot_dat_pop = tot_dat_push;
        model_last_wr = 1'b1;
        @(negedge clk);
        chk("abort_app_en", app_en, 1'b0);
        chk("abort_app_cmd_addr", {app_cmd, app_addr}, '0);
        chk("abort_busy_fin", {busy, burst_finish, app_wdf_wren}, '0);
        @(posedge clk); #1 rst_n = 1;
        n = 0;
        while ((pend.size() > 0 || app_rd_data_valid) && n < 200) begin
            @(negedge clk);
            if (app_rd_data_valid) chk("late_rd_valid", rd_burst_data_valid, 1'b0);
            n++;
        end
        chk("pend_drained", pend.size(), 0);
        do_single(0, 2, 28'h900, 0);

        repeat (5) @(negedge clk);
        chk("queues_empty", exp_cmd.size() + exp_rd.size() + exp_wdf.size() + exp_fin.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
